// File: rtl/dac_playback_pkg.sv
// Shared types and constants for the DAC playback controller.
// The word helper fixes the host byte order (byte0 ends up in the MSBs).
package dac_playback_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam int         FIFO_WORD_W  = 32;
  localparam int         HALF_W       = 16;
  localparam logic [7:0] MIN_RATE_DIV = 8'd1;

  function automatic logic [FIFO_WORD_W-1:0] byte_reverse(input logic [FIFO_WORD_W-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/dac_playback_ctrl_rate_tick_gen.sv
// Sample-period counter: fires a tick when div_cnt is zero, then reloads to
// the clamped divider so the period is max(rate_div,1)+1 cycles.
module rate_tick_gen
  import dac_playback_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic       enable,
  input  logic [7:0] rate_div,
  output logic       tick
);

  logic [7:0] div_cnt;
  logic [7:0] eff_div;

  assign eff_div = (rate_div < MIN_RATE_DIV) ? MIN_RATE_DIV : rate_div;
  assign tick    = enable && (div_cnt == 8'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (load) begin
      div_cnt <= '0;
    end else if (enable) begin
      div_cnt <= (div_cnt == 8'd0) ? eff_div : div_cnt - 8'd1;
    end
  end

endmodule

// File: rtl/dac_playback_ctrl.sv
// Drains the playback FIFO in the DAC clock domain and presents two-channel
// samples at a programmable rate, with start/stop, word count and status.
module dac_playback_ctrl
  import dac_playback_pkg::*;
#(
  parameter int          DAC_WIDTH = 16,
  parameter logic [15:0] IDLE_CODE = 16'h8000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic [31:0]            sample_count,
  input  logic [7:0]             rate_div,
  input  logic [FIFO_WORD_W-1:0] fifo_dout,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  output logic [DAC_WIDTH-1:0]   dac_data_1,
  output logic [DAC_WIDTH-1:0]   dac_data_2,
  output logic                   dac_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   underflow,
  output logic [31:0]            words_sent
);

  localparam logic [DAC_WIDTH-1:0] IDLE_DAC = IDLE_CODE[HALF_W-1 -: DAC_WIDTH];

  state_t                 state, next_state;
  logic [FIFO_WORD_W-1:0] hold_word;
  logic                   hold_valid;
  logic                   rd_inflight;
  logic [31:0]            sample_count_q;
  logic [7:0]             rate_div_q;
  logic [31:0]            words_fetched;
  logic                   tick;
  logic                   load_div;
  logic                   consume;
  logic                   accept_start;
  logic                   more_words;
  logic                   last_word;

  rate_tick_gen u_rate_tick_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load_div),
    .enable   (state == ST_RUN),
    .rate_div (rate_div_q),
    .tick     (tick)
  );

  assign busy       = (state != ST_IDLE);
  assign more_words = (sample_count_q == 32'd0) || (words_fetched != sample_count_q);
  assign last_word  = (sample_count_q != 32'd0) && ((words_sent + 32'd1) == sample_count_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  // A read may be issued in the same cycle the hold register is consumed,
  // which keeps a two-cycle sample period fully fed.
  always_comb begin
    next_state   = state;
    fifo_rd_en   = 1'b0;
    accept_start = 1'b0;
    load_div     = 1'b0;
    consume      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          accept_start = 1'b1;
          next_state   = ST_PRIME;
        end
      end
      ST_PRIME: begin
        if (stop) begin
          next_state = ST_IDLE;
        end else if (rd_inflight) begin
          load_div   = 1'b1;
          next_state = ST_RUN;
        end else if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop || done) begin
          next_state = ST_IDLE;
        end else begin
          consume    = tick && hold_valid;
          fifo_rd_en = (!hold_valid || consume) && !rd_inflight && !fifo_empty && more_words;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_word      <= '0;
      hold_valid     <= 1'b0;
      rd_inflight    <= 1'b0;
      sample_count_q <= '0;
      rate_div_q     <= '0;
      words_fetched  <= '0;
      words_sent     <= '0;
      dac_data_1     <= IDLE_DAC;
      dac_data_2     <= IDLE_DAC;
      dac_valid      <= 1'b0;
      done           <= 1'b0;
      underflow      <= 1'b0;
    end else begin
      dac_valid   <= 1'b0;
      done        <= 1'b0;
      rd_inflight <= fifo_rd_en;
      if (fifo_rd_en) words_fetched <= words_fetched + 32'd1;

      if (accept_start) begin
        sample_count_q <= sample_count;
        rate_div_q     <= rate_div;
        underflow      <= 1'b0;
        words_sent     <= '0;
        words_fetched  <= '0;
        hold_valid     <= 1'b0;
      end

      if (rd_inflight && next_state != ST_IDLE) begin
        hold_word  <= byte_reverse(fifo_dout);
        hold_valid <= 1'b1;
      end else if (consume) begin
        hold_valid <= 1'b0;
      end

      if (consume) begin
        dac_data_1 <= hold_word[FIFO_WORD_W-1 -: DAC_WIDTH];
        dac_data_2 <= hold_word[HALF_W-1 -: DAC_WIDTH];
        dac_valid  <= 1'b1;
        words_sent <= words_sent + 32'd1;
        done       <= last_word;
      end else if (state == ST_RUN && tick && !hold_valid && next_state == ST_RUN) begin
        underflow <= 1'b1;
      end

      // Leaving a run discards any held or in-flight word.
      if (state != ST_IDLE && next_state == ST_IDLE) begin
        dac_data_1  <= IDLE_DAC;
        dac_data_2  <= IDLE_DAC;
        hold_valid  <= 1'b0;
        rd_inflight <= 1'b0;
      end
    end
  end

endmodule
